// File: rtl/aqp_ovl_pkg.sv
// aqp_ovl_pkg: shared overlay text field positions, default geometry and renderer FSM states
package aqp_ovl_pkg;
  localparam int COLUMNS_DEF = 40;
  localparam int ROWS_DEF = 25;
  localparam int CHAR_LSB = 0;
  localparam int FG_LSB = 8;
  localparam int BG_LSB = 12;
  typedef enum logic [1:0] {IDLE, PREFETCH, ACTIVE, DONE} ovl_state_t;
endpackage

// File: rtl/aqp_ovl_text_render.sv
// aqp_ovl_text_render: fetches text/font data per scanline and serialises glyph rows into colour-index pixels
module aqp_ovl_text_render
  import aqp_ovl_pkg::*;
#(
  parameter int COLUMNS = COLUMNS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [7:0]  line_y,
  input  logic        pix_en,
  output logic [10:0] txt_addr,
  input  logic [15:0] txt_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        pix_valid,
  output logic [3:0]  pix_color,
  output logic        busy
);
  localparam logic [6:0] LASTCOL = 7'(COLUMNS - 1);
  localparam int VIS = ROWS * 8;
  ovl_state_t state, state_nx;
  logic [2:0] ly, pcnt;
  logic [10:0] base, row_base, font_q;
  logic [6:0] col;
  logic f0, f1, f2, next_full, start_ok, adv, load, last_pix;
  logic [3:0] pfg, pbg, nfg, nbg, fg, bg, ld_fg, ld_bg, cur_fg, cur_bg;
  logic [7:0] nbits, shreg, ld_bits, cur_bits;
  assign row_base = 11'(int'(line_y[7:3]) * COLUMNS);
  assign start_ok = 32'(line_y) < VIS;
  assign adv = state == ACTIVE && pix_en && !line_start;
  assign load = adv && pcnt == 3'd0;
  assign last_pix = adv && pcnt == 3'd7 && col == LASTCOL;
  assign ld_bits = next_full ? nbits : 8'h00;
  assign ld_fg = next_full ? nfg : fg;
  assign ld_bg = next_full ? nbg : bg;
  assign cur_bits = load ? ld_bits : shreg;
  assign cur_fg = load ? ld_fg : fg;
  assign cur_bg = load ? ld_bg : bg;
  assign font_addr = f1 ? {txt_data[CHAR_LSB+:8], ly} : font_q;
  assign busy = state == PREFETCH || state == ACTIVE;
  // state register
  always_ff @(posedge clk)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // line_start restarts from any state; prefetch completion enters ACTIVE; last pixel ends the line
  always_comb begin
    state_nx = state;
    if (line_start) state_nx = start_ok ? PREFETCH : DONE;
    else if (state == PREFETCH && f2) state_nx = ACTIVE;
    else if (last_pix) state_nx = DONE;
  end
  // fetch pipeline, next-char buffer and pixel serialiser
  always_ff @(posedge clk)
    if (!reset_n) begin
      {f0, f1, f2, next_full, pix_valid} <= '0;
      {txt_addr, font_q, base} <= '0;
      {ly, pcnt, col} <= '0;
      {pfg, pbg, nfg, nbg, fg, bg, pix_color} <= '0;
      {nbits, shreg} <= '0;
    end else begin
      f0 <= 1'b0;
      f1 <= f0 && !line_start;
      f2 <= f1 && !line_start;
      pix_valid <= adv;
      font_q <= font_addr;
      if (f1) begin
        pfg <= txt_data[FG_LSB+:4];
        pbg <= txt_data[BG_LSB+:4];
      end
      if (line_start) begin
        ly <= line_y[2:0];
        base <= row_base;
        col <= '0;
        pcnt <= '0;
        next_full <= 1'b0;
        if (start_ok) begin
          txt_addr <= row_base;
          f0 <= 1'b1;
        end
      end else if (adv) begin
        pix_color <= cur_bits[7] ? cur_fg : cur_bg;
        shreg <= {cur_bits[6:0], 1'b0};
        pcnt <= pcnt + 3'd1;
        if (pcnt == 3'd7) col <= col + 7'd1;
        if (load) begin
          fg <= ld_fg;
          bg <= ld_bg;
          next_full <= 1'b0;
          if (col != LASTCOL) begin
            txt_addr <= base + 11'(col) + 11'd1;
            f0 <= 1'b1;
          end
        end
      end
      if (f2 && !line_start) begin
        nbits <= font_data;
        nfg <= pfg;
        nbg <= pbg;
        next_full <= 1'b1;
      end
    end
endmodule

// File: tb/tb_aqp_ovl_text_render.sv
// tb_aqp_ovl_text_render: scoreboard bench for the overlay text renderer (40- and 80-column instances)
module tb_aqp_ovl_text_render;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;
  logic [1:0] ls, pe, pv, bz;
  logic [7:0] ly [2];
  logic [10:0] ta [2];
  logic [10:0] fa [2];
  logic [15:0] td [2];
  logic [7:0] fd [2];
  logic [3:0] pc [2];
  logic [15:0] tram [2048];
  logic [7:0] fram [2048];
  logic [3:0] q0 [$];
  logic [3:0] q1 [$];
  logic [10:0] alog [$];
  logic [10:0] last1 = '0;
  logic [3:0] hand [8] = '{4'd15, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd15};
  logic [10:0] t0;
  int tests = 0, fails = 0, cnt1 = 0, bad_fa = 0, bad;
  logic fa_chk = 1'b0;

  aqp_ovl_text_render #(.COLUMNS(40), .ROWS(25)) u40 (
    .clk(clk), .reset_n(reset_n), .line_start(ls[0]), .line_y(ly[0]), .pix_en(pe[0]),
    .txt_addr(ta[0]), .txt_data(td[0]), .font_addr(fa[0]), .font_data(fd[0]),
    .pix_valid(pv[0]), .pix_color(pc[0]), .busy(bz[0]));
  aqp_ovl_text_render #(.COLUMNS(80), .ROWS(25)) u80 (
    .clk(clk), .reset_n(reset_n), .line_start(ls[1]), .line_y(ly[1]), .pix_en(pe[1]),
    .txt_addr(ta[1]), .txt_data(td[1]), .font_addr(fa[1]), .font_data(fd[1]),
    .pix_valid(pv[1]), .pix_color(pc[1]), .busy(bz[1]));

  always @(posedge clk) begin
    td[0] <= tram[ta[0]];
    fd[0] <= fram[fa[0]];
    td[1] <= tram[ta[1]];
    fd[1] <= fram[fa[1]];
  end

  task automatic chk(input string n, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  function automatic logic [3:0] model(input int cols, input int y, input int p);
    logic [15:0] d;
    logic [7:0] b;
    d = tram[(y / 8) * cols + p / 8];
    b = fram[{d[7:0], 3'(y % 8)}];
    return b[7 - p % 8] ? d[11:8] : d[15:12];
  endfunction

  always @(negedge clk) begin
    if (pv[0] === 1'b1) begin
      if (q0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_extra_pix: got pixel %0d expected none", pc[0]);
      end else chk("a_pix", int'(pc[0]), int'(q0.pop_front()));
    end
    if (pv[1] === 1'b1) begin
      cnt1++;
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_extra_pix: got pixel %0d expected none", pc[1]);
      end else chk("b_pix", int'(pc[1]), int'(q1.pop_front()));
    end
    if (ta[1] !== last1) begin
      alog.push_back(ta[1]);
      last1 = ta[1];
    end
    if (fa_chk && fa[1][2:0] != 3'd7) bad_fa++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input int s, input int y);
    ls[s] = 1'b1;
    ly[s] = 8'(y);
    tick();
    ls[s] = 1'b0;
  endtask

  task automatic run_pix(input int s, input int cols, input int y, input int from, input int n, input int gap);
    for (int i = from; i < from + n; i++) begin
      pe[s] = 1'b1;
      if (s == 0) q0.push_back(model(cols, y, i));
      else q1.push_back(model(cols, y, i));
      tick();
      pe[s] = 1'b0;
      repeat (gap) tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    ls = '0;
    pe = '0;
    ly[0] = '0;
    ly[1] = '0;
    for (int i = 0; i < 2048; i++) begin
      tram[i] = 16'(i * 16'h03B5 + 16'h1234);
      fram[i] = 8'(i * 29 + 7);
    end
    tram[0] = 16'h2F41;
    fram[11'h208] = 8'h81;
    for (int i = 0; i < 5; i++) begin
      pe = i[0] ? 2'b11 : 2'b00;
      tick();
      chk("rst_pix_valid", int'(pv), 0);
      chk("rst_pix_color", int'(pc[0]), 0);
      chk("rst_busy", int'(bz), 0);
      chk("rst_txt_addr", int'(ta[0]), 0);
      chk("rst_font_addr", int'(fa[0]), 0);
    end
    pe = '0;
    reset_n = 1'b1;
    tick();
    start_line(0, 0);
    chk("a_txt_addr_row0", int'(ta[0]), 0);
    chk("a_busy_prefetch", int'(bz[0]), 1);
    tick();
    chk("a_font_addr_41", int'(fa[0]), 'h208);
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      pe[0] = 1'b1;
      q0.push_back(hand[i]);
      tick();
      pe[0] = 1'b0;
    end
    run_pix(0, 40, 0, 8, 312, 0);
    chk("a_busy_drop", int'(bz[0]), 0);
    tick();
    start_line(0, 0);
    tick();
    tick();
    tick();
    run_pix(0, 40, 0, 0, 320, 1);
    chk("a_busy_drop_slow", int'(bz[0]), 0);
    last1 = ta[1];
    alog.delete();
    cnt1 = 0;
    start_line(1, 199);
    chk("b_txt_addr_first", int'(ta[1]), 1920);
    tick();
    fa_chk = 1'b1;
    chk("b_font_addr_low", int'(fa[1][2:0]), 7);
    tick();
    tick();
    run_pix(1, 80, 199, 0, 640, 0);
    chk("b_busy_drop", int'(bz[1]), 0);
    fa_chk = 1'b0;
    tick();
    chk("b_pix_count", cnt1, 640);
    chk("b_addr_count", alog.size(), 80);
    bad = 0;
    foreach (alog[i]) if (alog[i] != 11'(1920 + i)) bad++;
    chk("b_addr_seq", bad, 0);
    chk("b_font_addr_low_all", bad_fa, 0);
    for (int i = 0; i < 6; i++) begin
      pe[1] = i[0];
      tick();
    end
    pe[1] = 1'b0;
    chk("b_done_busy", int'(bz[1]), 0);
    t0 = ta[0];
    start_line(0, 200);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      pe[0] = i[0];
      tick();
      if (bz[0] !== 1'b0 || ta[0] !== t0) bad++;
    end
    pe[0] = 1'b0;
    chk("a_y200_idle", bad, 0);
    start_line(0, 8);
    tick();
    tick();
    tick();
    run_pix(0, 40, 8, 0, 100, 0);
    start_line(0, 8);
    chk("a_abort_txt_addr", int'(ta[0]), 40);
    chk("a_abort_busy", int'(bz[0]), 1);
    pe[0] = 1'b1;
    tick();
    tick();
    tick();
    pe[0] = 1'b0;
    run_pix(0, 40, 8, 0, 320, 0);
    chk("a_abort_busy_drop", int'(bz[0]), 0);
    repeat (4) tick();
    chk("a_queue_drained", q0.size(), 0);
    chk("b_queue_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
